// File: rtl/m_stage_mem_unit.sv
// M-stage data-memory port for the pipelined MIPS core: owns the M and W pipeline
// registers, forms byte-lane store traffic and aligns/extends load results.
module m_stage_mem_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        e_valid,
    input  logic [3:0]  e_mem_op,
    input  logic [31:0] e_addr,
    input  logic [31:0] e_rt_data,
    input  logic [31:0] e_pc,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] m_data_addr,
    output logic [31:0] m_data_wdata,
    output logic [3:0]  m_data_byteen,
    input  logic [31:0] m_data_rdata,
    output logic [31:0] m_inst_addr,
    output logic        m_adel,
    output logic        m_ades,
    output logic        w_load_valid,
    output logic [31:0] w_load_data,
    output logic [31:0] w_pc
);
    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_LW   = 4'd1;
    localparam logic [3:0] OP_LH   = 4'd2;
    localparam logic [3:0] OP_LHU  = 4'd3;
    localparam logic [3:0] OP_LB   = 4'd4;
    localparam logic [3:0] OP_LBU  = 4'd5;
    localparam logic [3:0] OP_SW   = 4'd6;
    localparam logic [3:0] OP_SH   = 4'd7;
    localparam logic [3:0] OP_SB   = 4'd8;

    logic        r_vld_p1;
    logic [3:0]  r_op_p1;
    logic [31:0] r_addr_p1;
    logic [31:0] r_rt_p1;
    logic [31:0] r_pc_p1;

    logic        r_vld_p2;
    logic [3:0]  r_op_p2;
    logic [1:0]  r_lane_p2;
    logic [31:0] r_rdata_p2;
    logic [31:0] r_pc_p2;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_misaligned;
    logic [3:0]  w_byteen;
    logic [31:0] w_wdata;
    logic [15:0] w_half;
    logic [7:0]  w_byte;
    logic [31:0] w_load_word;

    function automatic logic [31:0] f_ext_half(input logic [15:0] half, input logic sgn);
        logic signed [15:0] s_half;
        s_half = signed'(half);
        return sgn ? 32'(s_half) : {16'd0, half};
    endfunction

    function automatic logic [31:0] f_ext_byte(input logic [7:0] b8, input logic sgn);
        logic signed [7:0] s_b8;
        s_b8 = signed'(b8);
        return sgn ? 32'(s_b8) : {24'd0, b8};
    endfunction

    // ---- E -> M stage boundary ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld_p1  <= 1'b0;
            r_op_p1   <= OP_NONE;
            r_addr_p1 <= '0;
            r_rt_p1   <= '0;
            r_pc_p1   <= '0;
        end else if (flush) begin
            r_vld_p1  <= 1'b0;
            r_op_p1   <= OP_NONE;
            r_addr_p1 <= '0;
            r_rt_p1   <= '0;
            r_pc_p1   <= '0;
        end else if (!stall) begin
            r_vld_p1  <= e_valid;
            r_op_p1   <= e_mem_op;
            r_addr_p1 <= e_addr;
            r_rt_p1   <= e_rt_data;
            r_pc_p1   <= e_pc;
        end
    end

    always_comb begin
        w_is_load    = 1'b0;
        w_is_store   = 1'b0;
        w_misaligned = 1'b0;
        w_byteen     = 4'b0000;
        w_wdata      = '0;
        case (r_op_p1)
            OP_LW: begin
                w_is_load    = 1'b1;
                w_misaligned = |r_addr_p1[1:0];
            end
            OP_LH, OP_LHU: begin
                w_is_load    = 1'b1;
                w_misaligned = r_addr_p1[0];
            end
            OP_LB, OP_LBU: w_is_load = 1'b1;
            OP_SW: begin
                w_is_store   = 1'b1;
                w_misaligned = |r_addr_p1[1:0];
                w_byteen     = 4'b1111;
                w_wdata      = r_rt_p1;
            end
            OP_SH: begin
                w_is_store   = 1'b1;
                w_misaligned = r_addr_p1[0];
                w_byteen     = r_addr_p1[1] ? 4'b1100 : 4'b0011;
                w_wdata      = {2{r_rt_p1[15:0]}};
            end
            OP_SB: begin
                w_is_store   = 1'b1;
                w_byteen     = 4'b0001 << r_addr_p1[1:0];
                w_wdata      = {4{r_rt_p1[7:0]}};
            end
            default: ;
        endcase
    end

    // A stalled store must not write until the cycle it actually leaves M.
    assign m_data_byteen = (r_vld_p1 && !w_misaligned && !stall) ? w_byteen : 4'b0000;
    assign m_data_wdata  = w_wdata;
    assign m_data_addr   = r_vld_p1 ? r_addr_p1 : '0;
    assign m_inst_addr   = r_vld_p1 ? r_pc_p1 : '0;
    assign m_adel        = r_vld_p1 & w_is_load & w_misaligned;
    assign m_ades        = r_vld_p1 & w_is_store & w_misaligned;

    // ---- M -> W stage boundary ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld_p2   <= 1'b0;
            r_op_p2    <= OP_NONE;
            r_lane_p2  <= 2'b00;
            r_rdata_p2 <= '0;
            r_pc_p2    <= '0;
        end else begin
            r_vld_p2   <= r_vld_p1 & w_is_load & ~w_misaligned & ~stall;
            r_op_p2    <= r_op_p1;
            r_lane_p2  <= r_addr_p1[1:0];
            r_rdata_p2 <= m_data_rdata;
            r_pc_p2    <= m_inst_addr;
        end
    end

    always_comb begin
        w_half      = r_lane_p2[1] ? r_rdata_p2[31:16] : r_rdata_p2[15:0];
        w_byte      = r_rdata_p2[8*r_lane_p2 +: 8];
        w_load_word = '0;
        if (r_vld_p2) begin
            case (r_op_p2)
                OP_LW:   w_load_word = r_rdata_p2;
                OP_LH:   w_load_word = f_ext_half(w_half, 1'b1);
                OP_LHU:  w_load_word = f_ext_half(w_half, 1'b0);
                OP_LB:   w_load_word = f_ext_byte(w_byte, 1'b1);
                OP_LBU:  w_load_word = f_ext_byte(w_byte, 1'b0);
                default: w_load_word = '0;
            endcase
        end
    end

    assign w_load_valid = r_vld_p2;
    assign w_load_data  = w_load_word;
    assign w_pc         = r_pc_p2;

endmodule
